// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo controller: TX FSM encoding, handshake timeout,
// default byte width and a saturating counter helper used by the optional statistics.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

    localparam int ACK_TIMEOUT    = 4;
    localparam int ACK_CNT_W      = $clog2(ACK_TIMEOUT);
    localparam int DEFAULT_DATA_W = 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular-buffer FIFO; pointers wrap naturally because DEPTH is a power of two.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo responder between UART receiver and transmitter: acks and buffers each received byte,
// then replays it one frame at a time. Define UART_ECHO_STATS_EN to add rx_total/drop_total.
module uart_echo_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_rdy,
    output logic                     rx_rdy_clr,
    output logic                     tx_wr_en,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
`ifdef UART_ECHO_STATS_EN
   ,output logic [15:0]              rx_total,
    output logic [15:0]              drop_total
`endif
);

    tx_state_e              state_q, state_d;
    logic [ACK_CNT_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic [DATA_W-1:0]      tx_data_q, tx_data_d;
    logic                   clr_q, clr_d;
    logic                   overflow_q, overflow_d;

    logic                   capture, push, pop, drop;
    logic                   fifo_full, fifo_empty;
    logic [DATA_W-1:0]      fifo_dout;

    // The receiver keeps rdy high for a cycle after our clear, so the cycle after a capture is ignored.
    assign capture    = rx_rdy & ~clr_q & ~rst;
    assign pop        = (state_q == IDLE) & ~fifo_empty & ~tx_busy;
    assign push       = capture & (~fifo_full | pop);
    assign drop       = capture & fifo_full & ~pop;
    assign clr_d      = capture;
    assign overflow_d = overflow_q | drop;

    assign rx_rdy_clr = capture;
    assign tx_wr_en   = (state_q == LAUNCH);
    assign tx_data    = tx_data_q;
    assign overflow   = overflow_q;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        tx_data_d = tx_data_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = LAUNCH;
                    tx_data_d = fifo_dout;
                end
            end
            LAUNCH: begin
                state_d   = WAIT_ACK;
                ack_cnt_d = '0;
            end
            // A transmitter that never raises busy must not stall the echo path forever.
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == ACK_CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_cnt_q  <= '0;
            tx_data_q  <= '0;
            clr_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_cnt_q  <= ack_cnt_d;
            tx_data_q  <= tx_data_d;
            clr_q      <= clr_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_ECHO_STATS_EN
    logic [15:0] rx_total_q, rx_total_d;
    logic [15:0] drop_total_q, drop_total_d;

    always_comb begin
        rx_total_d   = capture ? sat_inc16(rx_total_q) : rx_total_q;
        drop_total_d = drop ? sat_inc16(drop_total_q) : drop_total_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_total_q   <= '0;
            drop_total_q <= '0;
        end else begin
            rx_total_q   <= rx_total_d;
            drop_total_q <= drop_total_d;
        end
    end

    assign rx_total   = rx_total_q;
    assign drop_total = drop_total_q;
`endif

endmodule
